// File: rtl/add8_err_pkg.sv
// Shared widths, pair count, FSM state type and helpers for the 8-bit adder error meter.
package add8_err_pkg;

  localparam int unsigned SumAbsW   = 32;
  localparam int unsigned SumSqW    = 40;
  localparam int unsigned MaxAbsW   = 9;
  localparam int unsigned ErrCntW   = 17;
  localparam int unsigned SumHdW    = 20;
  localparam int unsigned PairCount = 65536;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/add8_err_delay.sv
// Aligns {valid, exact sum} with the adder-under-test latency; a plain wire at zero latency.
module add8_err_delay #(
  parameter int unsigned DUT_LAT = 1,
  parameter int unsigned W       = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DUT_LAT == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [W-1:0] r_pipe [DUT_LAT];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < int'(DUT_LAT); i++) begin
          r_pipe[i] <= '0;
        end
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < int'(DUT_LAT); i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign o_q = r_pipe[DUT_LAT-1];
  end

endmodule

// File: rtl/add8_err_meter.sv
// Exhaustive error-characterisation engine: sweeps all operand pairs through an 8-bit adder
// under test and accumulates |err|, err^2, max |err|, error count and Hamming distance.
module add8_err_meter
  import add8_err_pkg::*;
#(
  parameter int unsigned DUT_LAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [7:0]         o_op_a,
  output logic [7:0]         o_op_b,
  output logic               o_op_valid,
  input  logic [8:0]         i_aut_sum,
  output logic               o_busy,
  output logic               o_done,
  output logic [SumAbsW-1:0] o_sum_abs_err,
  output logic [SumSqW-1:0]  o_sum_sq_err,
  output logic [MaxAbsW-1:0] o_max_abs_err,
  output logic [ErrCntW-1:0] o_err_count,
  output logic [SumHdW-1:0]  o_sum_hd
);

  localparam logic [2:0] DrainLast = (DUT_LAT == 0) ? 3'd0 : 3'(DUT_LAT - 1);

  state_e       r_state, w_state_nxt;
  logic         r_start;
  logic [15:0]  r_cnt;
  logic [2:0]   r_drain;
  logic         w_accept, w_last;

  // start is registered, so the sweep begins one cycle after the edge that samples it
  assign w_accept = r_start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == 16'hFFFF);

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN:     if (w_last) w_state_nxt = (DUT_LAT == 0) ? DONE : DRAIN;
        DRAIN:   if (r_drain == DrainLast) w_state_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_start <= i_start;
      if (w_accept) begin
        r_cnt   <= '0;
        r_drain <= '0;
      end else begin
        if (r_state == RUN && !w_last) r_cnt <= r_cnt + 16'd1;
        if (r_state == DRAIN)          r_drain <= r_drain + 3'd1;
      end
    end
  end

  assign o_op_a     = r_cnt[15:8];
  assign o_op_b     = r_cnt[7:0];
  assign o_op_valid = (r_state == RUN);
  assign o_busy     = (r_state == RUN) || (r_state == DRAIN);
  assign o_done     = (r_state == DONE);

  logic [8:0] w_exact;
  logic [9:0] w_dly;
  logic       w_dly_valid;
  logic [8:0] w_dly_exact;

  assign w_exact = {1'b0, o_op_a} + {1'b0, o_op_b};

  add8_err_delay #(
    .DUT_LAT (DUT_LAT),
    .W       (10)
  ) u_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({o_op_valid, w_exact}),
    .o_q   (w_dly)
  );

  assign w_dly_valid = w_dly[9];
  assign w_dly_exact = w_dly[8:0];

  logic signed [9:0] w_diff;
  logic [8:0]        w_abs;
  logic [17:0]       w_sq;
  logic [3:0]        w_hd;

  assign w_diff = $signed({1'b0, i_aut_sum}) - $signed({1'b0, w_dly_exact});
  assign w_abs  = 9'(w_diff[9] ? -w_diff : w_diff);
  assign w_sq   = {9'b0, w_abs} * {9'b0, w_abs};
  assign w_hd   = popcount9(i_aut_sum ^ w_dly_exact);

  logic [SumAbsW-1:0] r_sum_abs;
  logic [SumSqW-1:0]  r_sum_sq;
  logic [MaxAbsW-1:0] r_max_abs;
  logic [ErrCntW-1:0] r_err_cnt;
  logic [SumHdW-1:0]  r_sum_hd;

  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) begin
      r_sum_abs <= '0;
      r_sum_sq  <= '0;
      r_max_abs <= '0;
      r_err_cnt <= '0;
      r_sum_hd  <= '0;
    end else if (w_dly_valid) begin
      r_sum_abs <= r_sum_abs + SumAbsW'(w_abs);
      r_sum_sq  <= r_sum_sq + SumSqW'(w_sq);
      r_err_cnt <= r_err_cnt + ErrCntW'(w_abs != 9'd0);
      r_sum_hd  <= r_sum_hd + SumHdW'(w_hd);
      if (w_abs > r_max_abs) r_max_abs <= w_abs;
    end
  end

  assign o_sum_abs_err = r_sum_abs;
  assign o_sum_sq_err  = r_sum_sq;
  assign o_max_abs_err = r_max_abs;
  assign o_err_count   = r_err_cnt;
  assign o_sum_hd      = r_sum_hd;

endmodule

// File: doc/add8_err_meter.md
# add8_err_meter

Sequential error-characterisation engine for 8-bit approximate adders. It generates all 65 536 operand pairs and drives them to an adder-under-test (AUT) at one pair per cycle. It takes the returned 9-bit sum after a fixed latency, compares it with an internally computed exact sum, and accumulates the library figures of merit: total |error|, total squared error, worst-case error, error count and total Hamming distance. It sits on the characterisation bench and in on-chip self-test wrappers, on the consuming side of every `add8_*` circuit.

## Interface
- `DUT_LAT`, 1, AUT latency in cycles from `op_a`/`op_b` to `aut_sum`; legal range 0..4 (0 = combinational AUT).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `op_a`  out  8  AUT operand A.
- `op_b`  out  8  AUT operand B.
- `op_valid`  out  1  high while a pair is being issued.
- `aut_sum`  in  9  AUT result, {carry, sum[7:0]}.
- `busy`  out  1  sweep in progress.
- `done`  out  1  metrics final; held until next accepted `start` or `rst`.
- `sum_abs_err`  out  32  Σ|approx − exact|.
- `sum_sq_err`  out  40  Σ(approx − exact)².
- `max_abs_err`  out  9  max |approx − exact|.
- `err_count`  out  17  number of pairs with approx ≠ exact.
- `sum_hd`  out  20  Σ popcount(approx ^ exact).

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → (start) RUN.
- `start` is accepted only in IDLE or DONE. While `busy`, `start` is ignored.
- Accepting `start` clears all accumulators and the 16-bit issue counter `cnt`, then enters RUN.
- RUN:
  - `op_valid` = 1, `op_a` = `cnt[15:8]`, `op_b` = `cnt[7:0]`, `cnt` increments every cycle.
  - At `cnt` = 16'hFFFF the last pair is issued and the FSM enters DRAIN. The counter wrap is not an error.
- Exact sum is `{1'b0,op_a} + {1'b0,op_b}`, 9 bits. It travels through a DUT_LAT-deep delay line together with a valid bit.
- Compare stage, registered: when the delayed valid bit is 1, it takes the signed 10-bit difference `aut_sum − exact` and updates all five accumulators in one cycle.
  - `max_abs_err` updates only on a strictly greater value.
- DRAIN lasts until the last delayed valid has been accumulated. The FSM then enters DONE and asserts `done`.
- Accumulators are sized never to overflow: worst case |err| = 511, ×65 536 pairs.
- `rst` in any state:
  - FSM returns to IDLE.
  - `cnt`, the delay line and all accumulators clear.
  - Any in-flight sweep is abandoned with no partial `done`.

## Timing
- Reset values: `op_a`=0, `op_b`=0, `op_valid`=0, `busy`=0, `done`=0, all metric outputs 0.
- Cycle numbering: edge E0 samples `start`. Cycle n is the cycle after edge En.
- Pair k (k = 0..65 535) is presented during cycle k+1. `aut_sum` for pair k is sampled in cycle k+1+DUT_LAT.
- Accumulator contribution of pair k is visible from cycle k+2+DUT_LAT.
- `busy` is high from cycle 1 to cycle 65 536+DUT_LAT inclusive.
- `done` rises in cycle 65 537+DUT_LAT. All metrics are final in that same cycle.
- `op_valid` is low outside RUN. `op_a`/`op_b` hold their last value in DRAIN and DONE.
- `start` together with `rst` in the same cycle: `rst` wins.

## Structure
- Package `add8_err_pkg` holds:
  - the metric widths (32/40/9/17/20);
  - the state enum `{IDLE, RUN, DRAIN, DONE}`;
  - the pair count 65 536.
- Sub-module `add8_err_delay` holds the DUT_LAT-deep shift register of {valid, exact[8:0]}. At DUT_LAT = 0 it is a pure wire.
- FSM, counter and compare/accumulate stage stay in the top level.

## Test plan
- **Exact AUT.** `aut_sum` = true sum, DUT_LAT=1 → every metric 0; `done` in cycle 65 538.
- **Stuck-LSB AUT.** `aut_sum` = true sum with bit 0 forced 0, DUT_LAT=0 →
  - `err_count`=32 768, `sum_abs_err`=32 768, `sum_sq_err`=32 768, `max_abs_err`=1, `sum_hd`=32 768;
  - `done` in cycle 65 537.
- **Carry-gated AUT.** The bit-1 carry-in is `a0&b0&~a6`, otherwise exact, DUT_LAT=2 →
  - `err_count`=8 192, `sum_abs_err`=16 384, `sum_sq_err`=32 768, `max_abs_err`=2;
  - these give MAE 0.25, EP 12.5 %.
- **Worst-case AUT.** `aut_sum` = 9'h000 always, DUT_LAT=4 →
  - `max_abs_err`=510, `err_count`=65 535;
  - `sum_abs_err`=16 711 680 (Σ over all pairs of (a+b)).
- **Reset and restart.** Assert `rst` at cycle 30 000 mid-sweep → all outputs 0 the next cycle and `done` never rises. A fresh `start` then reproduces the stuck-LSB figures exactly.
- **Start handling.** `start` pulses while `busy` → ignored, completion cycle unchanged. `start` in DONE → `done` falls, accumulators read 0 in cycle 1, and the sweep reruns.
